alu_sequencer: RTL and testbench

ALU_SEQUENCER -- requirements
Module: alu_sequencer

---
 rtl/alu_seq_if.sv | 41 ++++
 rtl/alu_sequencer.sv | 184 ++++++++++++++++++
 tb/tb_alu_sequencer.sv | 325 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_seq_if.sv
// alu_seq_if: rx byte, ALU result/flags and tx byte bundle
// between the ALU byte sequencer and its host.
interface alu_seq_if #(
   parameter int NB_DATA = 8
);
   logic [NB_DATA-1:0] i_rx_data;
   logic               i_rx_valid;
   logic [NB_DATA-1:0] i_alu_result;
   logic               i_alu_carry;
   logic               i_alu_zero;
   logic               i_tx_ready;
   logic [NB_DATA-1:0] o_alu_data;
   logic               o_enable_1;
   logic               o_enable_2;
   logic               o_enable_3;
   logic [NB_DATA-1:0] o_tx_data;
   logic               o_tx_start;
   logic               o_busy;
   logic               o_error;
   logic               o_overrun;

   modport slave (
      input  i_rx_data, i_rx_valid,
      input  i_alu_result, i_alu_carry, i_alu_zero,
      input  i_tx_ready,
      output o_alu_data,
      output o_enable_1, o_enable_2, o_enable_3,
      output o_tx_data, o_tx_start,
      output o_busy, o_error, o_overrun
   );

   modport master (
      output i_rx_data, i_rx_valid,
      output i_alu_result, i_alu_carry, i_alu_zero,
      output i_tx_ready,
      input  o_alu_data,
      input  o_enable_1, o_enable_2, o_enable_3,
      input  o_tx_data, o_tx_start,
      input  o_busy, o_error, o_overrun
   );
endinterface

// File: rtl/alu_sequencer.sv
// alu_sequencer: collects operand A, operand B and opcode bytes,
// loads them into an external ALU and returns result and flag bytes.
module alu_sequencer #(
   parameter int NB_DATA = 8,
   parameter int NB_OP   = 6
) (
   input  logic     i_clk,
   input  logic     i_reset,
   alu_seq_if.slave bus
);

   typedef enum logic [2:0] {
      GET_A, GET_B, GET_OP, LOAD_OP,
      SETTLE, SEND_RES, SEND_FLG, TX_GUARD
   } state_t;

   state_t r_state;
   state_t w_next;

   logic [NB_DATA-1:0] r_alu_data;
   logic [NB_DATA-1:0] r_tx_data;
   logic [NB_DATA-1:0] r_res;
   logic               r_carry;
   logic               r_zero;
   logic               r_en1;
   logic               r_en2;
   logic               r_en3;
   logic               r_tx_start;
   logic               r_busy;
   logic               r_error;
   logic               r_overrun;
   logic               r_ret_flg;

   logic [NB_OP-1:0]   w_op;
   logic               w_legal;
   logic               w_acc_a;
   logic               w_acc_b;
   logic               w_acc_op;
   logic               w_bad_op;
   logic               w_capture;
   logic               w_tx_res;
   logic               w_tx_flg;
   logic               w_ovr;

   assign w_op = bus.i_rx_data[NB_DATA-1:2];

   always_comb begin
      w_legal = 1'b0;
      case (w_op)
         NB_OP'('h20), NB_OP'('h22),
         NB_OP'('h24), NB_OP'('h25),
         NB_OP'('h26), NB_OP'('h27),
         NB_OP'('h02), NB_OP'('h03):
            w_legal = 1'b1;
         default: w_legal = 1'b0;
      endcase
   end

   always_comb begin
      w_next    = r_state;
      w_acc_a   = 1'b0;
      w_acc_b   = 1'b0;
      w_acc_op  = 1'b0;
      w_bad_op  = 1'b0;
      w_capture = 1'b0;
      w_tx_res  = 1'b0;
      w_tx_flg  = 1'b0;
      w_ovr     = 1'b0;
      unique case (r_state)
         GET_A: begin
            if (bus.i_rx_valid) begin
               w_acc_a = 1'b1;
               w_next  = GET_B;
            end
         end
         GET_B: begin
            if (bus.i_rx_valid) begin
               w_acc_b = 1'b1;
               w_next  = GET_OP;
            end
         end
         GET_OP: begin
            if (bus.i_rx_valid) begin
               if (w_legal) begin
                  w_acc_op = 1'b1;
                  w_next   = LOAD_OP;
               end else begin
                  w_bad_op = 1'b1;
                  w_next   = GET_A;
               end
            end
         end
         LOAD_OP: begin
            w_ovr  = bus.i_rx_valid;
            w_next = SETTLE;
         end
         SETTLE: begin
            w_ovr     = bus.i_rx_valid;
            w_capture = 1'b1;
            w_next    = SEND_RES;
         end
         SEND_RES: begin
            w_ovr = bus.i_rx_valid;
            if (bus.i_tx_ready) begin
               w_tx_res = 1'b1;
               w_next   = TX_GUARD;
            end
         end
         SEND_FLG: begin
            w_ovr = bus.i_rx_valid;
            if (bus.i_tx_ready) begin
               w_tx_flg = 1'b1;
               w_next   = TX_GUARD;
            end
         end
         TX_GUARD: begin
            // tx_ready is not looked at here, so no back-to-back start
            w_ovr  = bus.i_rx_valid;
            w_next = r_ret_flg ? SEND_FLG : GET_A;
         end
         default: w_next = GET_A;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         r_state    <= GET_A;
         r_alu_data <= '0;
         r_tx_data  <= '0;
         r_res      <= '0;
         r_carry    <= 1'b0;
         r_zero     <= 1'b0;
         r_en1      <= 1'b0;
         r_en2      <= 1'b0;
         r_en3      <= 1'b0;
         r_tx_start <= 1'b0;
         r_busy     <= 1'b0;
         r_error    <= 1'b0;
         r_overrun  <= 1'b0;
         r_ret_flg  <= 1'b0;
      end else begin
         r_state    <= w_next;
         r_en1      <= w_acc_a;
         r_en2      <= w_acc_b;
         r_en3      <= w_acc_op;
         r_tx_start <= w_tx_res | w_tx_flg;
         r_busy     <= (w_next != GET_A);
         if (w_acc_a | w_acc_b | w_acc_op)
            r_alu_data <= bus.i_rx_data;
         if (w_capture) begin
            r_res   <= bus.i_alu_result;
            r_carry <= bus.i_alu_carry;
            r_zero  <= bus.i_alu_zero;
         end
         if (w_tx_res) begin
            r_tx_data <= r_res;
            r_ret_flg <= 1'b1;
         end
         if (w_tx_flg) begin
            r_tx_data <= {{(NB_DATA-2){1'b0}}, r_carry, r_zero};
            r_ret_flg <= 1'b0;
         end
         if (w_bad_op)
            r_error <= 1'b1;
         else if (w_acc_a)
            r_error <= 1'b0;
         if (w_ovr)
            r_overrun <= 1'b1;
         else if (w_acc_a)
            r_overrun <= 1'b0;
      end
   end

   assign bus.o_alu_data = r_alu_data;
   assign bus.o_enable_1 = r_en1;
   assign bus.o_enable_2 = r_en2;
   assign bus.o_enable_3 = r_en3;
   assign bus.o_tx_data  = r_tx_data;
   assign bus.o_tx_start = r_tx_start;
   assign bus.o_busy     = r_busy;
   assign bus.o_error    = r_error;
   assign bus.o_overrun  = r_overrun;

endmodule

// File: tb/tb_alu_sequencer.sv
// tb_alu_sequencer: directed byte sequences against a queue-based
// transaction model plus literal expectations per scenario.
module tb_alu_sequencer;

   localparam int NB = 8;

   logic clk   = 1'b0;
   logic rst_n = 1'b1;

   always #5 clk = ~clk;

   alu_seq_if #(.NB_DATA(NB)) bus ();

   alu_sequencer #(
      .NB_DATA(NB),
      .NB_OP  (6)
   ) dut (
      .i_clk  (clk),
      .i_reset(rst_n),
      .bus    (bus)
   );

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string name,
                        input logic [31:0] act,
                        input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic fail(input string name);
      n_checks++;
      n_fail++;
      $display("FAIL %s", name);
   endtask

   logic [5:0] legal_ops [8] = '{6'h20, 6'h22, 6'h24, 6'h25,
                                 6'h26, 6'h27, 6'h02, 6'h03};

   function automatic logic is_legal(input logic [5:0] op);
      for (int i = 0; i < 8; i++)
         if (legal_ops[i] == op) return 1'b1;
      return 1'b0;
   endfunction

   // returns {carry, zero, result}
   function automatic logic [9:0] alu_fn(input logic [7:0] a,
                                         input logic [7:0] b,
                                         input logic [5:0] op);
      logic [8:0] s;
      logic [7:0] r;
      logic       c;
      s = '0;
      r = '0;
      c = 1'b0;
      case (op)
         6'h20: begin s = {1'b0, a} + {1'b0, b}; r = s[7:0]; c = s[8]; end
         6'h22: begin r = a - b; c = (a >= b); end
         6'h24: r = a & b;
         6'h25: r = a | b;
         6'h26: r = a ^ b;
         6'h27: r = ~(a | b);
         6'h02: r = b >> a[2:0];
         6'h03: r = $signed(b) >>> a[2:0];
         default: r = '0;
      endcase
      return {c, (r == 8'h00), r};
   endfunction

   logic [7:0] alu_a  = '0;
   logic [7:0] alu_b  = '0;
   logic [7:0] alu_op = '0;

   always @(posedge clk) begin
      if (bus.o_enable_1) alu_a  <= bus.o_alu_data;
      if (bus.o_enable_2) alu_b  <= bus.o_alu_data;
      if (bus.o_enable_3) alu_op <= bus.o_alu_data;
   end

   assign {bus.i_alu_carry, bus.i_alu_zero, bus.i_alu_result} =
      alu_fn(alu_a, alu_b, alu_op[7:2]);

   logic [9:0] exp_en [$];
   logic [7:0] exp_tx [$];
   logic [7:0] got_tx [$];
   int         m_phase = 0;
   logic [7:0] m_a = '0;
   logic [7:0] m_b = '0;

   task automatic model_rx(input logic [7:0] d);
      logic [9:0] r;
      case (m_phase)
         0: begin exp_en.push_back({2'd1, d}); m_a = d; m_phase = 1; end
         1: begin exp_en.push_back({2'd2, d}); m_b = d; m_phase = 2; end
         default: begin
            m_phase = 0;
            if (is_legal(d[7:2])) begin
               exp_en.push_back({2'd3, d});
               r = alu_fn(m_a, m_b, d[7:2]);
               exp_tx.push_back(r[7:0]);
               exp_tx.push_back({6'b0, r[9], r[8]});
            end
         end
      endcase
   endtask

   task automatic model_reset();
      exp_en.delete();
      exp_tx.delete();
      got_tx.delete();
      m_phase = 0;
   endtask

   always @(negedge clk) begin
      logic [3:0] s;
      logic [1:0] which;
      logic [9:0] e;
      logic [7:0] t;
      s = {bus.o_enable_1, bus.o_enable_2, bus.o_enable_3, bus.o_tx_start};
      if (s != 4'b0)
         check("strobe_onehot", 32'($countones(s)), 32'd1);
      if (bus.o_enable_1 | bus.o_enable_2 | bus.o_enable_3) begin
         which = bus.o_enable_1 ? 2'd1 : (bus.o_enable_2 ? 2'd2 : 2'd3);
         if (exp_en.size() == 0) begin
            fail("unexpected_enable");
         end else begin
            e = exp_en.pop_front();
            check("enable_which", 32'(which), 32'(e[9:8]));
            check("enable_data", 32'(bus.o_alu_data), 32'(e[7:0]));
         end
      end
      if (bus.o_tx_start) begin
         got_tx.push_back(bus.o_tx_data);
         if (exp_tx.size() == 0) begin
            fail("unexpected_tx_start");
         end else begin
            t = exp_tx.pop_front();
            check("tx_data", 32'(bus.o_tx_data), 32'(t));
         end
      end
   end

   task automatic pulse(input logic [7:0] d);
      @(posedge clk);
      #1;
      bus.i_rx_data  = d;
      bus.i_rx_valid = 1'b1;
      @(posedge clk);
      #1;
      bus.i_rx_valid = 1'b0;
   endtask

   task automatic send(input logic [7:0] d);
      model_rx(d);
      pulse(d);
   endtask

   task automatic wait_idle(input string name);
      int n;
      n = 0;
      do begin
         @(posedge clk);
         #1;
         n++;
      end while (bus.o_busy && n < 300);
      if (bus.o_busy)
         fail({name, "_idle_timeout"});
      else
         check({name, "_drained"},
               32'(exp_en.size() + exp_tx.size()), 32'd0);
   endtask

   task automatic do_reset();
      @(posedge clk);
      #3;
      rst_n = 1'b0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   initial begin
      bus.i_rx_data  = '0;
      bus.i_rx_valid = 1'b0;
      bus.i_tx_ready = 1'b1;
      #2 rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_busy", 32'(bus.o_busy), 32'd0);
      check("rst_error", 32'(bus.o_error), 32'd0);
      check("rst_overrun", 32'(bus.o_overrun), 32'd0);
      check("rst_alu_data", 32'(bus.o_alu_data), 32'd0);
      check("rst_tx_data", 32'(bus.o_tx_data), 32'd0);
      check("rst_strobes", 32'({bus.o_enable_1, bus.o_enable_2,
                                bus.o_enable_3, bus.o_tx_start}), 32'd0);
      rst_n = 1'b1;
      repeat (2) @(posedge clk);

      // ADD
      got_tx.delete();
      send(8'hF0);
      send(8'h20);
      send(8'h80);
      check("add_busy", 32'(bus.o_busy), 32'd1);
      wait_idle("add");
      check("add_ntx", 32'(got_tx.size()), 32'd2);
      if (got_tx.size() == 2) begin
         check("add_res", 32'(got_tx[0]), 32'h10);
         check("add_flg", 32'(got_tx[1]), 32'h02);
      end

      // SUB
      got_tx.delete();
      send(8'h05);
      send(8'h05);
      send(8'h88);
      wait_idle("sub");
      check("sub_busy_low", 32'(bus.o_busy), 32'd0);
      check("sub_ntx", 32'(got_tx.size()), 32'd2);
      if (got_tx.size() == 2) begin
         check("sub_res", 32'(got_tx[0]), 32'h00);
         check("sub_flg", 32'(got_tx[1]), 32'h03);
      end

      // backpressure
      got_tx.delete();
      bus.i_tx_ready = 1'b0;
      send(8'h7F);
      send(8'h01);
      send(8'h80);
      for (int i = 0; i < 20; i++) begin
         @(posedge clk);
         #1;
         check("bp_busy", 32'(bus.o_busy), 32'd1);
         check("bp_no_start", 32'(bus.o_tx_start), 32'd0);
      end
      bus.i_tx_ready = 1'b1;
      wait_idle("bp");
      check("bp_ntx", 32'(got_tx.size()), 32'd2);
      if (got_tx.size() == 2) begin
         check("bp_res", 32'(got_tx[0]), 32'h80);
         check("bp_flg", 32'(got_tx[1]), 32'h00);
      end

      // overrun
      got_tx.delete();
      bus.i_tx_ready = 1'b0;
      send(8'h03);
      send(8'h05);
      send(8'h88);
      repeat (4) @(posedge clk);
      pulse(8'h55);
      check("ovr_set", 32'(bus.o_overrun), 32'd1);
      check("ovr_no_tx_yet", 32'(got_tx.size()), 32'd0);
      bus.i_tx_ready = 1'b1;
      wait_idle("ovr");
      check("ovr_sticky", 32'(bus.o_overrun), 32'd1);
      check("ovr_ntx", 32'(got_tx.size()), 32'd2);
      if (got_tx.size() == 2) begin
         check("ovr_res", 32'(got_tx[0]), 32'hFE);
         check("ovr_flg", 32'(got_tx[1]), 32'h00);
      end

      // illegal opcode
      got_tx.delete();
      send(8'h11);
      send(8'h22);
      send(8'hFC);
      check("ill_error", 32'(bus.o_error), 32'd1);
      check("ill_busy", 32'(bus.o_busy), 32'd0);
      repeat (8) @(posedge clk);
      #1;
      check("ill_no_tx", 32'(got_tx.size()), 32'd0);
      check("ill_error_hold", 32'(bus.o_error), 32'd1);
      send(8'h01);
      check("ill_error_clr", 32'(bus.o_error), 32'd0);
      check("ill_overrun_clr", 32'(bus.o_overrun), 32'd0);
      check("ill_busy_b", 32'(bus.o_busy), 32'd1);
      @(posedge clk);
      do_reset();

      // reset while waiting for B
      send(8'h33);
      repeat (2) @(posedge clk);
      #3;
      check("pre_rst_busy", 32'(bus.o_busy), 32'd1);
      rst_n = 1'b0;
      model_reset();
      #1;
      check("arst_busy", 32'(bus.o_busy), 32'd0);
      check("arst_alu_data", 32'(bus.o_alu_data), 32'd0);
      check("arst_tx_data", 32'(bus.o_tx_data), 32'd0);
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      repeat (2) @(posedge clk);
      send(8'h44);
      send(8'h02);
      send(8'h90);
      wait_idle("rst");
      check("rst_ntx", 32'(got_tx.size()), 32'd2);
      if (got_tx.size() == 2) begin
         check("rst_res", 32'(got_tx[0]), 32'h00);
         check("rst_flg", 32'(got_tx[1]), 32'h01);
      end

      repeat (3) @(posedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_checks, n_fail);
      $finish;
   end

endmodule
